// File: rtl/inst_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_id_pkg
// Description : Shared instruction-ID encoding and RV OP-IMM field constants
// Revision    : 1.0 - initial release
// ============================================================================
package inst_id_pkg;

  // Width of every instruction ID carried through the pipeline
  localparam int INST_ID_LEN = 6;

  typedef logic [INST_ID_LEN-1:0] inst_id_t;

  // Instruction IDs; NONE_ID marks "not a legal instruction of this group"
  localparam inst_id_t NONE_ID  = 6'd0;
  localparam inst_id_t ADDI_ID  = 6'd1;
  localparam inst_id_t SLTI_ID  = 6'd2;
  localparam inst_id_t SLTIU_ID = 6'd3;
  localparam inst_id_t XORI_ID  = 6'd4;
  localparam inst_id_t ORI_ID   = 6'd5;
  localparam inst_id_t ANDI_ID  = 6'd6;
  localparam inst_id_t SLLI_ID  = 6'd7;
  localparam inst_id_t SRLI_ID  = 6'd8;
  localparam inst_id_t SRAI_ID  = 6'd9;

  // Major opcode of the OP-IMM group
  localparam logic [6:0] OP_IMM = 7'b0010011;

  // funct3 encodings within OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Upper immediate field that selects an arithmetic right shift
  localparam logic [6:0] SRA_UPPER_32 = 7'b0100000;
  localparam logic [5:0] SRA_UPPER_64 = 6'b010000;

endpackage : inst_id_pkg
`default_nettype wire

// File: rtl/op_imm_id_comb.sv
`default_nettype none
// ============================================================================
// Module      : op_imm_id_comb
// Description : Combinational decoder for the RV32I/RV64I OP-IMM group.
//               Produces ID, illegal flag, sign-extended immediate, shamt and
//               register indices from a raw 32-bit instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module op_imm_id_comb
  import inst_id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]            instr_i,
  output logic                   hit_o,
  output logic [INST_ID_LEN-1:0] id_o,
  output logic                   illegal_o,
  output logic [XLEN-1:0]        imm_o,
  output logic [5:0]             shamt_o,
  output logic [4:0]             rd_o,
  output logic [4:0]             rs1_o
);

  logic       w_upper_zero;  // shift upper field is all zero
  logic       w_upper_sra;   // shift upper field selects SRAI
  logic [5:0] w_shamt_raw;   // shamt as seen for this XLEN

  // The shift upper field and shamt width depend on the datapath width.
  // On RV32 bit 25 belongs to the upper field, so a set bit 25 simply fails
  // both the zero and SRA comparisons and ends up illegal.
  if (XLEN == 64) begin : g_rv64
    assign w_upper_zero = (instr_i[31:26] == 6'b000000);
    assign w_upper_sra  = (instr_i[31:26] == SRA_UPPER_64);
    assign w_shamt_raw  = instr_i[25:20];
  end else begin : g_rv32
    assign w_upper_zero = (instr_i[31:25] == 7'b0000000);
    assign w_upper_sra  = (instr_i[31:25] == SRA_UPPER_32);
    assign w_shamt_raw  = {1'b0, instr_i[24:20]};
  end

  assign imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign rd_o  = instr_i[11:7];
  assign rs1_o = instr_i[19:15];

  logic [INST_ID_LEN-1:0] w_id_raw;
  logic                   w_legal;
  logic [5:0]             w_shamt_sel;

  // funct3 / upper-field decode; only meaningful when the opcode hits
  always_comb begin
    w_id_raw    = NONE_ID;
    w_legal     = 1'b1;
    w_shamt_sel = 6'd0;
    case (instr_i[14:12])
      F3_ADD:  w_id_raw = ADDI_ID;
      F3_SLT:  w_id_raw = SLTI_ID;
      F3_SLTU: w_id_raw = SLTIU_ID;
      F3_XOR:  w_id_raw = XORI_ID;
      F3_OR:   w_id_raw = ORI_ID;
      F3_AND:  w_id_raw = ANDI_ID;
      F3_SLL: begin
        w_shamt_sel = w_shamt_raw;
        if (w_upper_zero) w_id_raw = SLLI_ID;
        else              w_legal  = 1'b0;
      end
      F3_SR: begin
        w_shamt_sel = w_shamt_raw;
        if (w_upper_zero)     w_id_raw = SRLI_ID;
        else if (w_upper_sra) w_id_raw = SRAI_ID;
        else                  w_legal  = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign hit_o     = (instr_i[6:0] == OP_IMM);
  assign illegal_o = hit_o && !w_legal;
  assign id_o      = (hit_o && w_legal) ? w_id_raw : NONE_ID;
  assign shamt_o   = hit_o ? w_shamt_sel : 6'd0;

endmodule : op_imm_id_comb
`default_nettype wire

// File: rtl/op_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : op_imm_decode_stage
// Description : One valid/ready pipeline stage decoding the OP-IMM group,
//               with flush and a saturating illegal-encoding counter.
// Revision    : 1.0 - initial release
// ============================================================================
module op_imm_decode_stage
  import inst_id_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INST_ID_LEN = inst_id_pkg::INST_ID_LEN,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_hit,
  output logic [INST_ID_LEN-1:0] out_instr_id,
  output logic [XLEN-1:0]        out_imm,
  output logic [5:0]             out_shamt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic                   out_illegal,
  output logic [CNT_W-1:0]       illegal_cnt
);

  // Decoder outputs for the instruction currently offered upstream
  logic                                w_hit;
  logic [inst_id_pkg::INST_ID_LEN-1:0] w_id;
  logic                                w_illegal;
  logic [XLEN-1:0]                     w_imm;
  logic [5:0]                          w_shamt;
  logic [4:0]                          w_rd;
  logic [4:0]                          w_rs1;

  op_imm_id_comb #(
    .XLEN (XLEN)
  ) u_dec (
    .instr_i   (in_instr),
    .hit_o     (w_hit),
    .id_o      (w_id),
    .illegal_o (w_illegal),
    .imm_o     (w_imm),
    .shamt_o   (w_shamt),
    .rd_o      (w_rd),
    .rs1_o     (w_rs1)
  );

  // Pipeline register and counter state
  logic                   valid_q,   valid_d;
  logic                   hit_q,     hit_d;
  logic [INST_ID_LEN-1:0] id_q,      id_d;
  logic [XLEN-1:0]        imm_q,     imm_d;
  logic [5:0]             shamt_q,   shamt_d;
  logic [4:0]             rd_q,      rd_d;
  logic [4:0]             rs1_q,     rs1_d;
  logic                   illegal_q, illegal_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;

  logic w_accept;

  // Ready does not depend on flush, so a flush never stalls upstream
  assign in_ready = !valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  // Next-state: flush dominates, then accept (load), then plain consume
  always_comb begin
    valid_d   = valid_q;
    hit_d     = hit_q;
    id_d      = id_q;
    imm_d     = imm_q;
    shamt_d   = shamt_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d   = 1'b1;
      hit_d     = w_hit;
      id_d      = INST_ID_LEN'(w_id);
      imm_d     = w_imm;
      shamt_d   = w_shamt;
      rd_d      = w_rd;
      rs1_d     = w_rs1;
      illegal_d = w_illegal;
      if (w_illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      id_q      <= INST_ID_LEN'(NONE_ID);
      imm_q     <= '0;
      shamt_q   <= 6'd0;
      rd_q      <= 5'd0;
      rs1_q     <= 5'd0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      id_q      <= id_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_hit      = hit_q;
  assign out_instr_id = id_q;
  assign out_imm      = imm_q;
  assign out_shamt    = shamt_q;
  assign out_rd       = rd_q;
  assign out_rs1      = rs1_q;
  assign out_illegal  = illegal_q;
  assign illegal_cnt  = cnt_q;

endmodule : op_imm_decode_stage
`default_nettype wire
